// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory-enable/ready requester: the state encoding,
// the default bus widths and the width of the WAIT-phase cycle counter.
package mem_if_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Four bits is enough for a count that saturates at 15. That also covers
  // TIMEOUT, whose largest allowed value is 15.
  localparam int unsigned            WAIT_CNT_W   = 4;
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

  // FSM encoding, kept as plain constants for compatibility with older tooling
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // True when the current WAIT cycle is the n-th one or a later one.
  // cnt holds the index of that cycle, counting from 0.
  function automatic logic wait_reached(logic [WAIT_CNT_W-1:0] cnt, int unsigned n);
    return (32'(cnt) + 32'd1) >= n;
  endfunction

endpackage

// File: rtl/mem_wait_tracker.sv
// Counts cycles since the last clear and remembers whether the controller has
// shown a busy (ready low) phase. The counter saturates at its maximum.
module mem_wait_tracker
  import mem_if_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  mem_ready,
  output logic [WAIT_CNT_W-1:0] count,
  output logic                  seen_low
);

  logic [WAIT_CNT_W-1:0] count_q;
  logic                  seen_low_q;

  // The count and the busy flag restart on clear and accumulate otherwise
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q    <= '0;
      seen_low_q <= 1'b0;
    end else begin
      if (count_q != WAIT_CNT_MAX) begin
        count_q <= count_q + 1'b1;
      end
      if (!mem_ready) begin
        seen_low_q <= 1'b1;
      end
    end
  end

  assign count    = count_q;
  assign seen_low = seen_low_q;

endmodule

// File: rtl/mem_access_initiator.sv
// Requester side of the mem_enable/mem_ready handshake. Each load or store
// becomes a one-cycle mem_enable pulse. The pipeline is stalled until the
// controller completes, and the result comes back as a one-cycle rsp_valid.
// Optional build macro MEM_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with err.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MIN_LAT = 1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic [1:0]            state_q, state_d;
  logic                  mem_enable_q;
  logic                  mem_write_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  err_q;

  logic                  latch_req;
  logic                  wait_clear;
  logic                  wait_complete;
  logic                  wait_abort;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  wait_seen_low;

  mem_wait_tracker u_wait_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (wait_clear),
    .mem_ready (mem_ready),
    .count     (wait_cnt),
    .seen_low  (wait_seen_low)
  );

  // Next-state logic and the per-state control strobes
  always_comb begin
    state_d       = state_q;
    latch_req     = 1'b0;
    wait_clear    = 1'b0;
    wait_complete = 1'b0;
    wait_abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A busy controller (ready low) keeps the request parked here
        if (req_valid && mem_ready) begin
          latch_req = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_clear = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Ready high counts as done once a busy phase has been seen. Without
        // a busy phase it counts only after MIN_LAT cycles, so a controller
        // that never drops ready still completes.
        if (mem_ready && (wait_seen_low || wait_reached(wait_cnt, MIN_LAT))) begin
          wait_complete = 1'b1;
          state_d       = ST_RESP;
        end else if (TIMEOUT_ON && wait_reached(wait_cnt, TIMEOUT)) begin
          wait_abort = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        // req_valid here is still the instruction being retired, so it is ignored
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall covers the request cycle through the last WAIT cycle and drops in RESP
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE:          stall = req_valid;
      ST_ISSUE, ST_WAIT: stall = 1'b1;
      default:          stall = 1'b0;
    endcase
  end

  // State, request latch, start pulse and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      // mem_enable is high only while in ISSUE
      mem_enable_q <= latch_req;
      if (latch_req) begin
        mem_write_q <= req_write;
        mem_addr_q  <= req_addr;
        mem_wdata_q <= req_wdata;
      end
      rsp_valid_q <= wait_complete || wait_abort;
      err_q       <= wait_abort;
      // Stores leave the last load data untouched
      if (!mem_write_q) begin
        if (wait_complete) begin
          rsp_rdata_q <= mem_rdata;
        end else if (wait_abort) begin
          rsp_rdata_q <= '0;
        end
      end
    end
  end

  assign mem_enable = mem_enable_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench for mem_access_initiator. Each request pushes its expected
// response; a monitor pops and compares on every rsp_valid. A small controller
// model supplies mem_ready/mem_rdata with a programmable latency.
module tb_mem_access_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        mem_enable;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Controller model
  int          lat        = 1;
  logic [31:0] model_data = 32'h0;
  logic        model_busy = 1'b0;
  int          model_cnt  = 0;
  logic        hold_low   = 1'b0;

  always #5 clk = ~clk;

  mem_access_initiator #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MIN_LAT (1),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err)
  );

  assign mem_ready = !model_busy && !hold_low;

  // Controller drops ready for lat-1 cycles after seeing mem_enable
  always @(posedge clk) begin
    if (mem_enable) begin
      mem_rdata <= model_data;
      if (lat > 1) begin
        model_busy <= 1'b1;
        model_cnt  <= lat - 1;
      end
    end else if (model_busy) begin
      if (model_cnt <= 1) model_busy <= 1'b0;
      model_cnt <= model_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic e);
    exp_t x;
    x.rdata = rdata;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin : mon
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=none rdata=%h", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, {31'b0, stall}, 32'd0);
    check({tag, "_mem_enable"}, {31'b0, mem_enable}, 32'd0);
    check({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  // One request starting now (cycle 0); checks pulse timing, stall and held bus
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata_exp, input int resp_cyc, input string tag);
    int cyc;
    bit got;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    push_exp(rdata_exp, 1'b0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, "_enable_issue"}, {31'b0, mem_enable}, 32'd1);
      end else begin
        check({tag, "_enable_quiet"}, {31'b0, mem_enable}, 32'd0);
      end
      if (cyc >= 1) begin
        check({tag, "_mem_write"}, {31'b0, mem_write}, {31'b0, wr});
        check({tag, "_mem_addr"}, mem_addr, addr);
        if (wr) check({tag, "_mem_wdata"}, mem_wdata, wdata);
      end
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        check({tag, "_resp_cycle"}, cyc, resp_cyc);
        check({tag, "_stall_resp"}, {31'b0, stall}, 32'd0);
      end else begin
        check({tag, "_stall"}, {31'b0, stall}, 32'd1);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_no_rsp actual=none required=rsp_valid", tag);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit got;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: load with a 1-cycle controller
    lat = 1;
    model_data = 32'hDEADBEEF;
    do_req(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 3, "t1");

    // 2: store with a 4-cycle controller; load data must stay put
    lat = 4;
    model_data = 32'hFFFF0000;
    do_req(1'b1, 32'h44, 32'h12345678, 32'hDEADBEEF, 6, "t2");

    // 3: controller busy for 3 cycles while the request waits
    hold_low  = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h48;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_busy_stall", {31'b0, stall}, 32'd1);
      check("t3_busy_enable", {31'b0, mem_enable}, 32'd0);
      @(posedge clk);
      #1;
    end
    hold_low   = 1'b0;
    lat        = 1;
    model_data = 32'h0BADF00D;
    do_req(1'b0, 32'h48, 32'h0, 32'h0BADF00D, 3, "t3");

    // 4: ready never drops, MIN_LAT=1
    model_data = 32'hCAFEF00D;
    do_req(1'b0, 32'h4C, 32'h0, 32'hCAFEF00D, 3, "t4");

    // 5: reset in WAIT abandons the access
    lat        = 4;
    model_data = 32'h11111111;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h50;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_after_rst");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    lat        = 1;
    model_data = 32'h22222222;
    do_req(1'b0, 32'h54, 32'h0, 32'h22222222, 3, "t5b");

    // 6: ready stuck low after issue
    model_data = 32'h33333333;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h58;
    @(posedge clk);
    #1;
    hold_low = 1'b1;
`ifdef MEM_TIMEOUT_EN
    push_exp(32'h0, 1'b1);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    check("t6_timeout_cycle", cyc, 17);
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("t6_stall_hold", {31'b0, stall}, 32'd1);
      check("t6_err_off", {31'b0, err}, 32'd0);
      @(posedge clk);
      #1;
    end
    push_exp(32'h33333333, 1'b0);
    hold_low = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t6_release_rsp", {31'b0, got}, 32'd1);
`endif
    hold_low  = 1'b0;
    req_valid = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
